seg7_display: RTL



---
 rtl/seg7_display_if.sv | 10 +
 rtl/seg7_display.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seg7_display_if.sv
// IO-bus store port from the MemOrIO decode into the seven-segment controller.
interface seg7_display_if;
  logic        io_write;
  logic        seg_ctrl;
  logic [2:0]  addr;
  logic [15:0] wdata;

  modport master (output io_write, seg_ctrl, addr, wdata);
  modport slave  (input  io_write, seg_ctrl, addr, wdata);
endinterface

// File: rtl/seg7_display.sv
// Memory-mapped 8-digit active-low seven-segment controller with tear-free value commit.
module seg7_display #(
  parameter int unsigned CLK_HZ      = 23000000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned GUARD       = 4,
  parameter int unsigned BLINK_SLOTS = 250
) (
  input  logic            clock,
  input  logic            reset,
  seg7_display_if.slave   bus,
  output logic [7:0]      seg_n,
  output logic [7:0]      an_n
);

  localparam int unsigned DIV     = CLK_HZ / SCAN_HZ;
  localparam int unsigned SLOT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIV - 1);
  localparam logic [SLOT_W-1:0]  GUARD_CNT  = SLOT_W'(GUARD);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_SLOTS - 1);

  logic [31:0]        pend_q, pend_d;
  logic [31:0]        show_q, show_d;
  logic [15:0]        ctrl_q, ctrl_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [2:0]         digit_q, digit_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [7:0]         seg_n_q, seg_n_d;
  logic [7:0]         an_n_q, an_n_d;

  logic        wr_en;
  logic        slot_wrap;
  logic [3:0]  nibble;
  logic [31:0] upper;
  logic [7:0]  blank_mask;
  logic [6:0]  seg_dec;
  logic        dark;

  // Control bits [7:3] are kept for software readback symmetry but drive nothing.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^ctrl_q[7:3];

  // All state flops, asynchronously cleared to a dark, disabled display.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q      <= '0;
      show_q      <= '0;
      ctrl_q      <= '0;
      slot_q      <= '0;
      digit_q     <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      seg_n_q     <= 8'hFF;
      an_n_q      <= 8'hFF;
    end else begin
      pend_q      <= pend_d;
      show_q      <= show_d;
      ctrl_q      <= ctrl_d;
      slot_q      <= slot_d;
      digit_q     <= digit_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      seg_n_q     <= seg_n_d;
      an_n_q      <= an_n_d;
    end
  end

  // Register writes, scan timing, blink timing and full-scan commit of the pending value.
  always_comb begin
    pend_d      = pend_q;
    ctrl_d      = ctrl_q;
    show_d      = show_q;
    slot_d      = slot_q + SLOT_W'(1);
    digit_d     = digit_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;

    wr_en     = bus.io_write & bus.seg_ctrl;
    slot_wrap = (slot_q == SLOT_LAST);

    if (wr_en) begin
      case (bus.addr)
        3'd0:    pend_d[15:0]  = bus.wdata;
        3'd2:    pend_d[31:16] = bus.wdata;
        3'd4:    ctrl_d        = bus.wdata;
        default: ;
      endcase
    end

    if (slot_wrap) begin
      slot_d  = '0;
      digit_d = digit_q + 3'd1;
      // Commit samples pend before any same-cycle write, so a racing store lands next scan.
      if (digit_q == 3'd7) begin
        show_d = pend_q;
      end
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Per-digit blanking decision and hex decode for the output flops.
  always_comb begin
    nibble     = show_q[{digit_q, 2'b00} +: 4];
    upper      = show_q >> {digit_q, 2'b00};
    blank_mask = ctrl_q[15:8];
    seg_dec    = 7'h7F;

    case (nibble)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase

    dark = !ctrl_q[0]
        || (slot_q < GUARD_CNT)
        || blank_mask[digit_q]
        || (ctrl_q[2] && blink_ph_q)
        || (ctrl_q[1] && (digit_q != 3'd0) && (upper == 32'd0));

    if (dark) begin
      an_n_d  = 8'hFF;
      seg_n_d = 8'hFF;
    end else begin
      an_n_d  = ~(8'd1 << digit_q);
      seg_n_d = {1'b1, seg_dec};
    end
  end

  assign seg_n = seg_n_q;
  assign an_n  = an_n_q;

endmodule
